// File: rtl/rev_shift_lights.sv
// rtl/rev_shift_lights.sv - shift-light controller: thermometer bar, rev limiter with hysteresis, blink, shift pulse
module rev_shift_lights #(
  parameter int RPM_WIDTH  = 14,
  parameter int N_LEDS     = 8,
  parameter int RPM_START  = 6000,
  parameter int RPM_LIMIT  = 10800,
  parameter int HYST       = 300,
  parameter int BLINK_HALF = 3250000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [RPM_WIDTH-1:0] rpm,
  output logic [N_LEDS-1:0]    leds,
  output logic                 limiter,
  output logic                 shift_pulse
);

  localparam int STEP = (RPM_LIMIT - RPM_START) / N_LEDS;
  localparam int XW   = RPM_WIDTH + 1;
  localparam int CW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [XW-1:0] START_X   = XW'(RPM_START);
  localparam logic [XW-1:0] LIMIT_X   = XW'(RPM_LIMIT);
  localparam logic [XW-1:0] RELEASE_X = XW'(RPM_LIMIT - HYST);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_BAR,
    S_LIMIT
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nx;
  logic                phase;
  logic                phase_nx;
  logic                entering;
  logic [XW-1:0]       rpm_x;
  logic [N_LEDS-1:0]   bar;
  logic [N_LEDS-1:0]   leds_nx;

  assign rpm_x = {1'b0, rpm};

  always_comb begin
    bar = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      bar[i] = (rpm_x >= XW'(RPM_START + i * STEP));
    end
  end

  // Hysteresis only applies while already limited; BAR uses plain thresholds.
  always_comb begin
    state_nx = S_OFF;
    if (!enable) begin
      state_nx = S_OFF;
    end else if (rpm_x >= LIMIT_X) begin
      state_nx = S_LIMIT;
    end else if ((state == S_LIMIT) && (rpm_x >= RELEASE_X)) begin
      state_nx = S_LIMIT;
    end else if (rpm_x >= START_X) begin
      state_nx = S_BAR;
    end else begin
      state_nx = S_OFF;
    end
  end

  assign entering = (state_nx == S_LIMIT) && (state != S_LIMIT);

  // Blink restarts on every entry so the first flash is a full "on" half-period.
  always_comb begin
    cnt_nx   = '0;
    phase_nx = 1'b1;
    if ((state_nx == S_LIMIT) && !entering) begin
      if (cnt == CNT_LAST) begin
        cnt_nx   = '0;
        phase_nx = ~phase;
      end else begin
        cnt_nx   = cnt + CW'(1);
        phase_nx = phase;
      end
    end
  end

  always_comb begin
    leds_nx = '0;
    case (state_nx)
      S_BAR:   leds_nx = bar;
      S_LIMIT: leds_nx = {N_LEDS{phase_nx}};
      default: leds_nx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_OFF;
      cnt         <= '0;
      phase       <= 1'b1;
      leds        <= '0;
      limiter     <= 1'b0;
      shift_pulse <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      phase       <= phase_nx;
      leds        <= leds_nx;
      limiter     <= (state_nx == S_LIMIT);
      shift_pulse <= entering;
    end
  end

endmodule
